// File: rtl/huffman_pkg.sv
// Shared definitions for the streaming Huffman encoder.
//   SYM_W/CODE_W/LEN_W defaults : symbol, max code and code-length widths
//   enc_state_t                 : encoder control states (run, drain, emit last word)
package huffman_pkg;

    localparam int unsigned SYM_W  = 7;
    localparam int unsigned CODE_W = 10;
    localparam int unsigned LEN_W  = 4;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StLast
    } enc_state_t;

endpackage

// File: rtl/huffman_bit_packer.sv
// MSB-first bit accumulator for variable-length codes.
//   s1_valid_i/s1_code_i/s1_len_i : staged code waiting to be appended
//   last_i                        : present the partial remainder as the final word
//   out_ready_i                   : consumer takes the presented word
//   merge_o                       : staged code is appended this cycle
//   acc_cnt_o                     : number of buffered bits
//   out_data_o/out_valid_o/out_last_o/out_nbits_o : output word interface
module huffman_bit_packer
    import huffman_pkg::*;
#(
    parameter int unsigned CodeW = CODE_W,
    parameter int unsigned LenW  = LEN_W,
    parameter int unsigned OutW  = 8,
    localparam int unsigned AccW    = OutW + CodeW,
    localparam int unsigned AccCntW = $clog2(AccW + 1),
    localparam int unsigned NbW     = $clog2(OutW + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               s1_valid_i,
    input  logic [CodeW-1:0]   s1_code_i,
    input  logic [LenW-1:0]    s1_len_i,
    input  logic               last_i,
    input  logic               out_ready_i,
    output logic               merge_o,
    output logic [AccCntW-1:0] acc_cnt_o,
    output logic [OutW-1:0]    out_data_o,
    output logic               out_valid_o,
    output logic               out_last_o,
    output logic [NbW-1:0]     out_nbits_o
);

    // Buffered bits are kept left-aligned; everything below acc_cnt_q is zero, so the top
    // OutW bits are already the zero-padded final word when fewer than OutW remain.
    logic [AccW-1:0]    acc_q, acc_d, code_ext;
    logic [AccCntW-1:0] acc_cnt_q, acc_cnt_d;
    logic               full, pop;

    assign full        = acc_cnt_q >= AccCntW'(OutW);
    assign merge_o     = s1_valid_i & ~full;
    assign out_valid_o = full | last_i;
    assign pop         = out_valid_o & out_ready_i;
    assign out_data_o  = acc_q[AccW-1 -: OutW];
    assign out_last_o  = last_i;
    assign acc_cnt_o   = acc_cnt_q;

    // Left-justify the code so its first bit lands at the accumulator MSB.
    assign code_ext = {s1_code_i, {OutW{1'b0}}} << (LenW'(CodeW) - s1_len_i);

    always_comb begin
        out_nbits_o = '0;
        if (out_valid_o) begin
            out_nbits_o = last_i ? NbW'(acc_cnt_q) : NbW'(OutW);
        end
    end

    always_comb begin
        acc_d     = acc_q;
        acc_cnt_d = acc_cnt_q;
        if (merge_o) begin
            acc_d     = acc_q | (code_ext >> acc_cnt_q);
            acc_cnt_d = acc_cnt_q + AccCntW'(s1_len_i);
        end else if (pop) begin
            if (last_i) begin
                acc_d     = '0;
                acc_cnt_d = '0;
            end else begin
                acc_d     = acc_q << OutW;
                acc_cnt_d = acc_cnt_q - AccCntW'(OutW);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            acc_q     <= '0;
            acc_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

endmodule

// File: rtl/huffman_table.sv
// Combinational symbol-to-code lookup.
//   ascii_i : input symbol
//   code_o  : code, right-aligned (bit len_o-1 is the first bit sent)
//   len_o   : code length in bits; 0 means the symbol is unmapped
// The table is prefix-free: 0xxx, 10xxxxxxxx, 1100x, 111.
module huffman_table
    import huffman_pkg::*;
#(
    parameter int unsigned SymW  = SYM_W,
    parameter int unsigned CodeW = CODE_W,
    parameter int unsigned LenW  = LEN_W
) (
    input  logic [SymW-1:0]  ascii_i,
    output logic [CodeW-1:0] code_o,
    output logic [LenW-1:0]  len_o
);

    always_comb begin
        code_o = '0;
        len_o  = '0;
        case (ascii_i)
            SymW'(7'h20): begin code_o = CodeW'(3'b111);         len_o = LenW'(3);  end
            SymW'(7'h2C): begin code_o = CodeW'(5'b11001);       len_o = LenW'(5);  end
            SymW'(7'h2E): begin code_o = CodeW'(5'b11000);       len_o = LenW'(5);  end
            SymW'(7'h41): begin code_o = CodeW'(4'b0000);        len_o = LenW'(4);  end
            SymW'(7'h42): begin code_o = CodeW'(4'b0001);        len_o = LenW'(4);  end
            SymW'(7'h43): begin code_o = CodeW'(4'b0010);        len_o = LenW'(4);  end
            SymW'(7'h44): begin code_o = CodeW'(4'b0011);        len_o = LenW'(4);  end
            SymW'(7'h45): begin code_o = CodeW'(4'b0100);        len_o = LenW'(4);  end
            SymW'(7'h46): begin code_o = CodeW'(4'b0101);        len_o = LenW'(4);  end
            SymW'(7'h47): begin code_o = CodeW'(4'b0110);        len_o = LenW'(4);  end
            SymW'(7'h48): begin code_o = CodeW'(4'b0111);        len_o = LenW'(4);  end
            SymW'(7'h5A): begin code_o = CodeW'(10'b1011010011); len_o = LenW'(10); end
            default: begin
                code_o = '0;
                len_o  = '0;
            end
        endcase
    end

endmodule

// File: rtl/huffman_stream_encoder.sv
// Streaming Huffman encoder: symbol handshake, one staging register, bit packer, flush FSM.
//   clk_i, reset_i             : clock, asynchronous active-high reset
//   in_ascii_i/in_valid_i/in_ready_o : symbol input handshake
//   flush_i                    : request to emit the final partial word (honoured in run state)
//   out_data_o/out_valid_o/out_ready_i/out_last_o/out_nbits_o : packed word output
//   flush_done_o               : one-cycle pulse when a flush completes
//   sym_count_o                : accepted symbols, wrapping
//   err_unmapd_o               : sticky, a zero-length (unmapped) symbol was accepted
module huffman_stream_encoder
    import huffman_pkg::*;
#(
    parameter int unsigned SymW  = SYM_W,
    parameter int unsigned CodeW = CODE_W,
    parameter int unsigned LenW  = LEN_W,
    parameter int unsigned OutW  = 8,
    parameter int unsigned CntW  = 16,
    localparam int unsigned AccCntW = $clog2(OutW + CodeW + 1),
    localparam int unsigned NbW     = $clog2(OutW + 1)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [SymW-1:0] in_ascii_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic            flush_i,
    output logic [OutW-1:0] out_data_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            out_last_o,
    output logic [NbW-1:0]  out_nbits_o,
    output logic            flush_done_o,
    output logic [CntW-1:0] sym_count_o,
    output logic            err_unmapd_o
);

    logic [CodeW-1:0]   tbl_code, s1_code_q, s1_code_d;
    logic [LenW-1:0]    tbl_len, s1_len_q, s1_len_d;
    logic               s1_valid_q, s1_valid_d;
    enc_state_t         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               merge, accept;
    logic [AccCntW-1:0] acc_cnt;

    huffman_table #(
        .SymW  (SymW),
        .CodeW (CodeW),
        .LenW  (LenW)
    ) u_table (
        .ascii_i (in_ascii_i),
        .code_o  (tbl_code),
        .len_o   (tbl_len)
    );

    huffman_bit_packer #(
        .CodeW (CodeW),
        .LenW  (LenW),
        .OutW  (OutW)
    ) u_packer (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .s1_valid_i  (s1_valid_q),
        .s1_code_i   (s1_code_q),
        .s1_len_i    (s1_len_q),
        .last_i      (state_q == StLast),
        .out_ready_i (out_ready_i),
        .merge_o     (merge),
        .acc_cnt_o   (acc_cnt),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_last_o  (out_last_o),
        .out_nbits_o (out_nbits_o)
    );

    // Held low while reset is asserted; the stage frees up in the same cycle it merges.
    assign in_ready_o   = ~reset_i & (state_q == StRun) & (~s1_valid_q | merge);
    assign accept       = in_valid_i & in_ready_o;
    assign sym_count_o  = cnt_q;
    assign err_unmapd_o = err_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s1_len_d   = s1_len_q;
        if (merge) begin
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_code_d  = tbl_code;
            s1_len_d   = tbl_len;
        end
        cnt_d = cnt_q + CntW'(accept);
        err_d = err_q | (accept & (tbl_len == '0));
    end

    always_comb begin
        state_d      = state_q;
        flush_done_o = 1'b0;
        case (state_q)
            StRun: begin
                if (flush_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!s1_valid_q && (acc_cnt < AccCntW'(OutW))) begin
                    if (acc_cnt != '0) begin
                        state_d = StLast;
                    end else begin
                        flush_done_o = 1'b1;
                        state_d      = StRun;
                    end
                end
            end
            StLast: begin
                if (out_ready_i) begin
                    flush_done_o = 1'b1;
                    state_d      = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StRun;
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s1_len_q   <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_code_q  <= s1_code_d;
            s1_len_q   <= s1_len_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_huffman_stream_encoder.sv
// Bench for huffman_stream_encoder: a bit-queue reference model checked every cycle,
// plus directed scenarios with hand-computed words.
module tb_huffman_stream_encoder;

    localparam int unsigned OutW = 8;
    localparam int unsigned CntW = 4;
    localparam int unsigned NbW  = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [6:0]      in_ascii = '0;
    logic            in_valid = 1'b0;
    logic            flush = 1'b0;
    logic            out_ready = 1'b0;
    logic            in_ready, out_valid, out_last, flush_done, err_unmapd;
    logic [OutW-1:0] out_data;
    logic [NbW-1:0]  out_nbits;
    logic [CntW-1:0] sym_count;

    int total = 0;
    int bad = 0;

    // Reference state, owned by the compare process.
    bit              q[$];
    int              exp_cnt = 0;
    bit              exp_err = 0;
    bit              prev_stall = 0;
    logic [OutW-1:0] held_data;
    logic [NbW-1:0]  held_nbits;
    logic            held_last;
    logic [OutW-1:0] got_words[$];
    logic [OutW-1:0] last_data = '0;
    logic [NbW-1:0]  last_nbits = '0;

    huffman_stream_encoder #(
        .OutW (OutW),
        .CntW (CntW)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .in_ascii_i   (in_ascii),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .flush_i      (flush),
        .out_data_o   (out_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_last_o   (out_last),
        .out_nbits_o  (out_nbits),
        .flush_done_o (flush_done),
        .sym_count_o  (sym_count),
        .err_unmapd_o (err_unmapd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Code book as a bit string, first bit sent at index 0.
    function automatic string ref_bits(input logic [6:0] s);
        case (s)
            7'h20:   return "111";
            7'h2C:   return "11001";
            7'h2E:   return "11000";
            7'h41:   return "0000";
            7'h42:   return "0001";
            7'h43:   return "0010";
            7'h44:   return "0011";
            7'h45:   return "0100";
            7'h46:   return "0101";
            7'h47:   return "0110";
            7'h48:   return "0111";
            7'h5A:   return "1011010011";
            default: return "";
        endcase
    endfunction

    always @(negedge clk) begin
        logic [OutW-1:0] w;
        string           b;
        if (reset) begin
            q.delete();
            exp_cnt    = 0;
            exp_err    = 0;
            prev_stall = 0;
        end else begin
            check("sym_count", 32'(sym_count), 32'(exp_cnt));
            check("err_unmapd", 32'(err_unmapd), 32'(exp_err));
            if (prev_stall) begin
                check("hold_data", 32'(out_data), 32'(held_data));
                check("hold_nbits", 32'(out_nbits), 32'(held_nbits));
                check("hold_last", 32'(out_last), 32'(held_last));
            end
            if (out_valid) begin
                w = '0;
                if (out_last) begin
                    for (int i = 0; i < OutW; i++) begin
                        w = {w[OutW-2:0], (i < q.size()) ? q[i] : 1'b0};
                    end
                    check("last_nbits", 32'(out_nbits), 32'(q.size()));
                    check("last_data", 32'(out_data), 32'(w));
                    if (out_ready) begin
                        last_data  = out_data;
                        last_nbits = out_nbits;
                        q.delete();
                    end
                end else begin
                    check("word_nbits", 32'(out_nbits), 32'(OutW));
                    if (q.size() < OutW) begin
                        check("word_underflow", 32'(q.size()), 32'(OutW));
                    end else begin
                        for (int i = 0; i < OutW; i++) begin
                            w = {w[OutW-2:0], q[i]};
                        end
                        check("word_data", 32'(out_data), 32'(w));
                        if (out_ready) begin
                            for (int i = 0; i < OutW; i++) begin
                                void'(q.pop_front());
                            end
                            got_words.push_back(out_data);
                        end
                    end
                end
            end else begin
                check("idle_last", 32'(out_last), 32'd0);
            end
            prev_stall = out_valid & ~out_ready;
            held_data  = out_data;
            held_nbits = out_nbits;
            held_last  = out_last;
            if (in_valid && in_ready) begin
                b = ref_bits(in_ascii);
                for (int i = 0; i < b.len(); i++) begin
                    q.push_back(b[i] == "1");
                end
                exp_cnt = (exp_cnt + 1) % (1 << CntW);
                if (b.len() == 0) begin
                    exp_err = 1;
                end
            end
        end
    end

    // Present a symbol and return one cycle after it is accepted.
    task automatic send(input logic [6:0] s);
        bit got = 0;
        in_ascii = s;
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            check("send_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for flush_done; n counts cycles from the current one.
    task automatic flush_wait(output int n, output bit saw_valid, output bit done_on_last);
        bit got = 0;
        n            = 0;
        saw_valid    = 0;
        done_on_last = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (out_valid) saw_valid = 1;
            if (flush_done) begin
                got          = 1;
                done_on_last = out_valid & out_last & out_ready;
                break;
            end
        end
        if (!got) begin
            check("flush_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(output int n, output bit saw_valid, output bit done_on_last);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        flush_wait(n, saw_valid, done_on_last);
    endtask

    initial begin
        int n, k, base;
        bit sv, dl;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_nbits", 32'(out_nbits), 32'd0);
        check("rst_flush_done", 32'(flush_done), 32'd0);
        check("rst_sym_count", 32'(sym_count), 32'd0);
        check("rst_err", 32'(err_unmapd), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset mid-stream with a word pending
        out_ready = 1'b0;
        send(7'h41);
        send(7'h42);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 10);
        check("t1_valid_before_reset", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t1_out_valid", 32'(out_valid), 32'd0);
        check("t1_sym_count", 32'(sym_count), 32'd0);
        check("t1_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        do_flush(n, sv, dl);
        check("t1_flush_cycles", 32'(n), 32'd1);
        check("t1_flush_noword", 32'(sv), 32'd0);

        // Eight 4-bit codes, two per word
        out_ready = 1'b1;
        base = got_words.size();
        send(7'h41);
        send(7'h42);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!out_valid && k < 10);
        check("t2_latency", 32'(k), 32'd2);
        @(posedge clk);
        #1;
        for (int i = 2; i < 8; i++) begin
            send(7'(7'h41 + i));
        end
        repeat (6) @(negedge clk);
        check("t2_word_count", 32'(got_words.size() - base), 32'd4);
        if (got_words.size() - base >= 4) begin
            check("t2_w0", 32'(got_words[base]), 32'h01);
            check("t2_w1", 32'(got_words[base+1]), 32'h23);
            check("t2_w2", 32'(got_words[base+2]), 32'h45);
            check("t2_w3", 32'(got_words[base+3]), 32'h67);
        end
        @(posedge clk);
        #1;

        // One 3-bit code then flush
        send(7'h20);
        do_flush(n, sv, dl);
        check("t3_done_on_pop", 32'(dl), 32'd1);
        check("t3_last_data", 32'(last_data), 32'hE0);
        check("t3_last_nbits", 32'(last_nbits), 32'd3);

        // Backpressure: stall until in_ready drops, then release
        out_ready = 1'b0;
        base = got_words.size();
        send(7'h44);
        send(7'h45);
        send(7'h46);
        in_ascii = 7'h47;
        in_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (in_ready && k < 10);
        check("t4_ready_drop", 32'(in_ready), 32'd0);
        check("t4_valid_stall", 32'(out_valid), 32'd1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(7'h47);
        send(7'h48);
        do_flush(n, sv, dl);
        check("t4_word_count", 32'(got_words.size() - base), 32'd2);
        if (got_words.size() - base >= 2) begin
            check("t4_w0", 32'(got_words[base]), 32'h34);
            check("t4_w1", 32'(got_words[base+1]), 32'h56);
        end
        check("t4_last_data", 32'(last_data), 32'h70);
        check("t4_last_nbits", 32'(last_nbits), 32'd4);

        // 10-bit code on top of 7 buffered bits, flush in the same cycle as its accept
        base = got_words.size();
        send(7'h20);
        send(7'h41);
        in_ascii = 7'h5A;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        check("t5_ready_at_flush", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        flush_wait(n, sv, dl);
        check("t5_word_count", 32'(got_words.size() - base), 32'd2);
        if (got_words.size() - base >= 2) begin
            check("t5_w0", 32'(got_words[base]), 32'hE1);
            check("t5_w1", 32'(got_words[base+1]), 32'h69);
        end
        check("t5_last_data", 32'(last_data), 32'h80);
        check("t5_last_nbits", 32'(last_nbits), 32'd1);

        // Unmapped symbol; count has wrapped (17 since reset, 4-bit counter)
        check("t6_err_before", 32'(err_unmapd), 32'd0);
        send(7'h21);
        @(negedge clk);
        check("t6_err_set", 32'(err_unmapd), 32'd1);
        check("t6_sym_count", 32'(sym_count), 32'd2);
        @(posedge clk);
        #1;
        do_flush(n, sv, dl);
        check("t6_flush_cycles", 32'(n), 32'd1);
        check("t6_flush_noword", 32'(sv), 32'd0);
        check("t6_err_sticky", 32'(err_unmapd), 32'd1);
        send(7'h2E);
        do_flush(n, sv, dl);
        check("t6_last_data", 32'(last_data), 32'hC0);
        check("t6_last_nbits", 32'(last_nbits), 32'd5);
        check("t6_sym_count_end", 32'(sym_count), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
